// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges synchronised reset requests into active-low domain
// resets, holds them for a stretch period, then releases domains in order.
module rst_seq_ctrl #(
  parameter int NUM_SRC = 3,
  parameter int NUM_DOM = 3,
  parameter int SYNC_DP = 2,
  parameter int STRETCH = 16,
  parameter int GAP     = 4
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  input  logic               cause_clr_i,
  output logic [NUM_DOM-1:0] rst_n_o,
  output logic               done_o,
  output logic [NUM_SRC-1:0] cause_o
);
  localparam int CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DOM + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_e;

  // state_q is the observable FSM state for checkers bound to this block.
  state_e                            state_q, state_d;
  logic   [CNT_W-1:0]                cnt_q, cnt_d;
  logic   [IDX_W-1:0]                idx_q, idx_d;
  logic   [NUM_DOM-1:0]              rst_n_q, rst_n_d;
  logic                              done_q, done_d;
  logic   [NUM_SRC-1:0]              cause_q, cause_d;
  logic   [SYNC_DP-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic   [NUM_SRC-1:0]              req_s;
  logic                              act;

  assign req_s = sync_q[SYNC_DP-1];
  assign act   = |(req_s & src_en_i);

  always_comb begin
    sync_d  = {sync_q[SYNC_DP-2:0], req_i};
    // A request on the same edge as a clear must still be recorded.
    cause_d = (cause_q & ~{NUM_SRC{cause_clr_i}}) | (req_s & src_en_i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    if (act) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end
        S_STRETCH: begin
          if (cnt_q == CNT_W'(STRETCH - 1)) begin
            cnt_d      = '0;
            idx_d      = '0;
            rst_n_d[0] = 1'b1;
            if (NUM_DOM == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_q == CNT_W'(GAP - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            for (int d = 1; d < NUM_DOM; d++) begin
              if (int'(idx_q) + 1 == d) rst_n_d[d] = 1'b1;
            end
            // Releasing the last domain completes the sequence.
            if (int'(idx_q) == NUM_DOM - 2) begin
              state_d = S_RUN;
              done_d  = 1'b1;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      sync_q  <= sync_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign done_o  = done_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a default instance and a minimal-config instance,
// checked each cycle against a quiet-time model plus directed edge counts.
module tb_rst_seq_ctrl;
  localparam int SYNC_A = 2, ST_A = 16, GAP_A = 4, DOM_A = 3;
  localparam int SYNC_B = 3, ST_B = 1, GAP_B = 1, DOM_B = 1;

  logic clk;
  logic rst_a, clr_a, rst_b, clr_b;
  logic [2:0] req_a, en_a, req_b, en_b;
  logic [DOM_A-1:0] rst_n_a;
  logic [DOM_B-1:0] rst_n_b;
  logic done_a, done_b;
  logic [2:0] cause_a, cause_b;

  int n_checks = 0;
  int n_errors = 0;

  rst_seq_ctrl #(.NUM_SRC(3), .NUM_DOM(DOM_A), .SYNC_DP(SYNC_A), .STRETCH(ST_A), .GAP(GAP_A)) u_dut_a (
    .clk(clk), .rst_i(rst_a), .req_i(req_a), .src_en_i(en_a), .cause_clr_i(clr_a),
    .rst_n_o(rst_n_a), .done_o(done_a), .cause_o(cause_a)
  );

  rst_seq_ctrl #(.NUM_SRC(3), .NUM_DOM(DOM_B), .SYNC_DP(SYNC_B), .STRETCH(ST_B), .GAP(GAP_B)) u_dut_b (
    .clk(clk), .rst_i(rst_b), .req_i(req_b), .src_en_i(en_b), .cause_clr_i(clr_b),
    .rst_n_o(rst_n_b), .done_o(done_b), .cause_o(cause_b)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a domain is released once the merged request has been quiet long
  // enough: q quiet edges, domain i free when q >= STRETCH+1+i*GAP.
  function automatic logic [7:0] rel_vec(input int q, input int st, input int gp, input int nd);
    rel_vec = '0;
    for (int i = 0; i < nd; i++) rel_vec[i] = (q >= st + 1 + i * gp);
  endfunction

  logic [2:0] hist_a[$];
  logic [2:0] hist_b[$];
  int q_a = 0, q_b = 0;
  logic [2:0] cause_m_a = '0, cause_m_b = '0;
  logic [7:0] exp_rst_a = '0, exp_rst_b = '0;
  logic exp_done_a = 1'b0, exp_done_b = 1'b0;
  logic exp_valid = 1'b0;

  initial begin
    logic [2:0] rs;
    forever begin
      @(posedge clk);
      if (rst_a) begin
        hist_a.delete();
        for (int i = 0; i < SYNC_A; i++) hist_a.push_back(3'b000);
        q_a = 0;
        cause_m_a = '0;
      end else begin
        rs = hist_a.pop_front();
        hist_a.push_back(req_a);
        if (|(rs & en_a)) q_a = 0;
        else q_a++;
        cause_m_a = (cause_m_a & ~{3{clr_a}}) | (rs & en_a);
      end
      if (rst_b) begin
        hist_b.delete();
        for (int i = 0; i < SYNC_B; i++) hist_b.push_back(3'b000);
        q_b = 0;
        cause_m_b = '0;
      end else begin
        rs = hist_b.pop_front();
        hist_b.push_back(req_b);
        if (|(rs & en_b)) q_b = 0;
        else q_b++;
        cause_m_b = (cause_m_b & ~{3{clr_b}}) | (rs & en_b);
      end
      exp_rst_a  = rel_vec(q_a, ST_A, GAP_A, DOM_A);
      exp_done_a = (q_a >= ST_A + 1 + (DOM_A - 1) * GAP_A);
      exp_rst_b  = rel_vec(q_b, ST_B, GAP_B, DOM_B);
      exp_done_b = (q_b >= ST_B + 1 + (DOM_B - 1) * GAP_B);
      exp_valid  = 1'b1;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_valid) begin
        check("cyc_rst_n_a", rst_n_a, exp_rst_a[DOM_A-1:0]);
        check("cyc_done_a", done_a, exp_done_a);
        check("cyc_cause_a", cause_a, cause_m_a);
        check("cyc_rst_n_b", rst_n_b, exp_rst_b[DOM_B-1:0]);
        check("cyc_done_b", done_b, exp_done_b);
        check("cyc_cause_b", cause_b, cause_m_b);
      end
    end
  end

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       get_sig = rst_n_a[0];
      1:       get_sig = rst_n_a[1];
      2:       get_sig = rst_n_a[2];
      3:       get_sig = done_a;
      4:       get_sig = rst_n_b[0];
      default: get_sig = done_b;
    endcase
  endfunction

  // Counts rising edges until the selected output reaches lvl (seen on negedge).
  task automatic wait_sig(input int sel, input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (get_sig(sel) != lvl && n < budget);
    if (get_sig(sel) != lvl) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_sig%0d: got no change in %0d edges required level %0b", sel, budget, lvl);
    end
  endtask

  // driver / directed sequence
  initial begin
    int n;
    rst_a = 1'b1; req_a = '0; en_a = 3'b111; clr_a = 1'b0;
    rst_b = 1'b1; req_b = '0; en_b = 3'b111; clr_b = 1'b0;

    // release timing from reset
    repeat (3) @(negedge clk);
    check("t1_reset_rst_n", rst_n_a, 0);
    check("t1_reset_done", done_a, 0);
    check("t1_reset_cause", cause_a, 0);
    rst_a = 1'b0;
    wait_sig(0, 1'b1, 60, n); check("t1_rel0_edges", n, 17);
    wait_sig(1, 1'b1, 60, n); check("t1_rel1_edges", n, 4);
    check("t1_done_low_at_rel1", done_a, 0);
    wait_sig(2, 1'b1, 60, n); check("t1_rel2_edges", n, 4);
    check("t1_done_with_rel2", done_a, 1);
    check("t1_cause", cause_a, 0);

    // request pulse in RUN
    req_a = 3'b010;
    wait_sig(0, 1'b0, 60, n); check("t2_assert_edges", n, 3);
    check("t2_all_low", rst_n_a, 0);
    repeat (2) @(negedge clk);
    req_a = '0;
    check("t2_cause", cause_a, 3'b010);
    wait_sig(0, 1'b1, 60, n); check("t2_rel0_edges", n, 19);

    // request mid-release: domain 1 rises, then all drop together
    repeat (2) @(negedge clk);
    req_a = 3'b001;
    wait_sig(0, 1'b0, 60, n); check("t3_assert_edges", n, 3);
    check("t3_all_low", rst_n_a, 0);
    repeat (2) @(negedge clk);
    req_a = '0;
    wait_sig(0, 1'b1, 60, n); check("t3_rel0_edges", n, 19);
    wait_sig(1, 1'b1, 60, n); check("t3_rel1_edges", n, 4);
    wait_sig(2, 1'b1, 60, n); check("t3_rel2_edges", n, 4);
    check("t3_done", done_a, 1);
    check("t3_cause", cause_a, 3'b011);

    // masking
    en_a = 3'b011; req_a = 3'b100;
    repeat (10) @(negedge clk);
    check("t4_masked_rst_n", rst_n_a, 3'b111);
    check("t4_masked_done", done_a, 1);
    check("t4_masked_cause2", cause_a[2], 0);
    en_a = 3'b111;
    wait_sig(0, 1'b0, 60, n); check("t4_enable_edges", n, 1);
    check("t4_cause", cause_a, 3'b111);
    req_a = '0;
    wait_sig(3, 1'b1, 60, n); check("t4_done_edges", n, 27);

    // cause clear and the set-wins race
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    check("t5_clear_idle", cause_a, 0);
    req_a = 3'b001;
    repeat (2) @(negedge clk);
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    check("t5_set_wins", cause_a, 3'b001);
    req_a = '0;
    repeat (4) @(negedge clk);
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    check("t5_clear_after", cause_a, 0);
    wait_sig(3, 1'b1, 60, n); check("t5_done_edges", n, 22);

    // rst_i mid-operation behaves like power-up
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    check("tr_rst_n", rst_n_a, 0);
    check("tr_done", done_a, 0);
    wait_sig(0, 1'b1, 60, n); check("tr_rel0_edges", n, 17);

    // minimal configuration instance
    rst_b = 1'b0;
    wait_sig(4, 1'b1, 20, n); check("t6_boot_edges", n, 2);
    check("t6_boot_done", done_b, 1);
    req_b = 3'b001;
    wait_sig(4, 1'b0, 20, n); check("t6_assert_edges", n, 4);
    check("t6_cause", cause_b, 3'b001);
    req_b = '0;
    wait_sig(4, 1'b1, 20, n); check("t6_rel_edges", n, 5);
    check("t6_done_same_edge", done_b, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised reset sequencer: the next-generation core reset controller. It merges NUM_SRC asynchronous reset requests (JTAG, watchdog, software, ...) into NUM_DOM active-low domain resets. After the last request drops, it stretches reset, then releases the domains in order with a programmable gap, and records the request cause. It sits at SoC top between the external/debug reset sources and the core, bus and peripheral reset nets.

Parameters:
NUM_SRC, 3, number of reset request inputs (1..16)
NUM_DOM, 3, number of sequenced reset domains; domain 0 is released first (1..8)
SYNC_DP, 2, synchronizer flop stages per request input (>=2)
STRETCH, 16, cycles reset is held after the last request deasserts (>=1)
GAP, 4, cycles between consecutive domain releases (>=1)

Ports:
clk  in  1  system clock
rst_i  in  1  synchronous active-high reset; one clock, sync reset, polarity and synchronicity fixed
req_i  in  NUM_SRC  asynchronous active-high reset requests
src_en_i  in  NUM_SRC  per-source enable; a disabled source is ignored (quasi-static)
cause_clr_i  in  1  single-cycle pulse that clears cause_o
rst_n_o  out  NUM_DOM  active-low domain resets
done_o  out  1  high when all domains are released (state RUN)
cause_o  out  NUM_SRC  sticky record of sources that caused a reset

Behaviour:
- Synchronizers:
  - Each req_i bit passes through SYNC_DP flops to give req_s.
  - rst_i clears the flops to 0.
  - act = |(req_s & src_en_i).
- FSM states:
  - HOLD (reset state): all rst_n_o = 0, done_o = 0.
  - STRETCH: all rst_n_o = 0.
  - RELEASE: domains released one by one.
  - RUN: all rst_n_o = 1, done_o = 1.
- Transitions:
  - HOLD: stays while act = 1. On an edge where act = 0, go to STRETCH with cnt = 0.
  - STRETCH: cnt increments each edge. At the edge where cnt == STRETCH-1, go to RELEASE, set cnt = 0, idx = 0, and register rst_n_o[0] = 1.
  - RELEASE: cnt increments. At the edge where cnt == GAP-1, set rst_n_o[idx+1] = 1, increment idx, and clear cnt. The edge that releases domain NUM_DOM-1 also moves the FSM to RUN. If NUM_DOM == 1, STRETCH goes directly to RUN.
  - Any state: act = 1 at an edge goes to HOLD. All rst_n_o go to 0 on that same edge and cnt/idx clear. This includes a request arriving mid-stretch or mid-release; there is no partial release.
- All outputs are registered; no combinational path from any input to rst_n_o or done_o.
- Latency:
  - rst_n_o[0] rises SYNC_DP+STRETCH+1 clk edges after the first edge that samples req_i low.
  - rst_n_o[i] rises i*GAP edges after rst_n_o[0].
  - Assertion: rst_n_o falls SYNC_DP+1 edges after req_i rises.
- Once released, rst_n_o[i] stays 1 until the FSM re-enters HOLD. Domains released earlier are never reasserted on their own.
- Counters:
  - cnt width = $clog2(max(STRETCH, GAP)+1).
  - idx width = $clog2(NUM_DOM+1).
  - Neither wraps: both clear on every state change.
- Cause register:
  - cause_o[k] sets on any edge with req_s[k] & src_en_i[k].
  - It is cleared by cause_clr_i; set wins if both occur on the same edge.
  - rst_i clears it to 0.
  - Disabled sources never set it.
- Reset values (rst_i high): state = HOLD, rst_n_o = 0, done_o = 0, cause_o = 0, cnt = 0, idx = 0.
- rst_i asserted mid-operation: identical to power-up. The sequence restarts after rst_i drops and act == 0.

Test Plan:
1. Release timing: defaults, rst_i high 3 cycles then low, req_i = 0 → rst_n_o[0] rises 17 edges after rst_i drops; rst_n_o[1] 4 edges later, rst_n_o[2] 8 edges later; done_o rises with rst_n_o[2]; cause_o = 0.
2. Request pulse: in RUN, req_i[1] high 5 cycles → all rst_n_o low 3 edges after rise; cause_o = 3'b010; rst_n_o[0] high again 19 edges after req_i[1] falls.
3. Request mid-release: req_i[0] rises 2 cycles after rst_n_o[0] goes high → all domains low together 3 edges later; the full STRETCH+GAP sequence restarts after the request drops.
4. Masking: src_en_i = 3'b011, req_i[2] held high → no reset, cause_o[2] stays 0; setting src_en_i[2] = 1 then forces HOLD.
5. Cause clear race: cause_clr_i pulses on the same edge req_s[0] is high → cause_o[0] stays 1; a clear with no active request → 0.
6. Config sweep: NUM_DOM = 1, STRETCH = 1, GAP = 1, SYNC_DP = 3 → rst_n_o[0] rises 5 edges after req_i falls; done_o rises on the same edge.
